// File: rtl/ir_encoder_if.sv
// Handshake and LED-side signals of the pulse-distance IR transmitter.
// The master side requests frames; the slave side is the encoder.
interface ir_encoder_if;
  logic        enable;
  logic        start;
  logic [31:0] command;
  logic        busy;
  logic        done;
  logic        ir_env;
  logic        ir_out;

  modport master (
    output enable, start, command,
    input  busy, done, ir_env, ir_out
  );

  modport slave (
    input  enable, start, command,
    output busy, done, ir_env, ir_out
  );
endinterface

// File: rtl/ir_encoder.sv
// Pulse-distance IR transmitter: leader, 32 LSB-first bit cells and a stop mark.
// All timing advances only on enabled ticks; the envelope is optionally carrier-modulated.
module ir_encoder #(
  parameter int unsigned T_LEAD_MARK  = 225000,
  parameter int unsigned T_START      = 337500,
  parameter int unsigned T_BIT0       = 28125,
  parameter int unsigned T_BIT1       = 56250,
  parameter int unsigned T_MARK       = 14000,
  parameter int unsigned CARRIER_HALF = 329,
  parameter int unsigned CARRIER_EN   = 1,
  parameter int unsigned INVERT       = 0,
  parameter int unsigned CW           = 21
) (
  input logic         clk,
  input logic         rst,
  ir_encoder_if.slave bus
);

  if (!(T_MARK < T_BIT0 && T_BIT0 < T_BIT1 && T_LEAD_MARK < T_START &&
        64'(T_START) < (64'd1 << CW) && CARRIER_HALF > 0 &&
        64'(CARRIER_HALF) < (64'd1 << CW))) begin : gen_param_check
    $error("ir_encoder: illegal timing parameters");
  end

  localparam logic [CW-1:0] DurLead   = CW'(T_LEAD_MARK);
  localparam logic [CW-1:0] DurLeadSp = CW'(T_START - T_LEAD_MARK);
  localparam logic [CW-1:0] DurMark   = CW'(T_MARK);
  localparam logic [CW-1:0] DurSp0    = CW'(T_BIT0 - T_MARK);
  localparam logic [CW-1:0] DurSp1    = CW'(T_BIT1 - T_MARK);
  localparam logic [CW-1:0] CarHalf   = CW'(CARRIER_HALF);
  localparam logic          CarrierOn = (CARRIER_EN != 0);
  localparam logic          InvBit    = (INVERT != 0);

  typedef enum logic [2:0] {
    StIdle,
    StLead,
    StLeadSp,
    StBitMark,
    StBitSp,
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   t_q, t_d;
  logic [31:0]     sr_q, sr_d;
  logic [4:0]      bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]   car_cnt_q, car_cnt_d;
  logic            phase_q, phase_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            env_q, env_d;
  logic            out_q, out_d;
  logic [CW-1:0]   dur;
  logic            last;
  logic            mark_d;

  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      StLead:   dur = DurLead;
      StLeadSp: dur = DurLeadSp;
      StBitSp:  dur = sr_q[0] ? DurSp1 : DurSp0;
      default:  dur = DurMark;
    endcase
    last = (t_q == dur - CW'(1));

    if (state_q == StIdle) begin
      // start is honoured on any edge here, enabled or not
      if (bus.start) begin
        state_d   = StLead;
        sr_d      = bus.command;
        bit_cnt_d = '0;
        t_d       = '0;
        busy_d    = 1'b1;
      end
    end else if (bus.enable) begin
      if (last) begin
        t_d = '0;
        unique case (state_q)
          StLead:    state_d = StLeadSp;
          StLeadSp:  state_d = StBitMark;
          StBitMark: state_d = StBitSp;
          StBitSp: begin
            sr_d      = sr_q >> 1;
            bit_cnt_d = bit_cnt_q + 5'd1;
            state_d   = (bit_cnt_q == 5'd31) ? StStop : StBitMark;
          end
          default: begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        endcase
      end else begin
        t_d = t_q + CW'(1);
      end
    end
  end

  // Carrier phase restarts high at every mark entry so each burst begins with light.
  always_comb begin
    mark_d    = (state_d == StLead) || (state_d == StBitMark) || (state_d == StStop);
    env_d     = mark_d;
    car_cnt_d = car_cnt_q;
    phase_d   = phase_q;
    if (mark_d && (state_d != state_q)) begin
      phase_d   = 1'b1;
      car_cnt_d = '0;
    end else if (!mark_d) begin
      phase_d   = 1'b0;
      car_cnt_d = '0;
    end else if (bus.enable) begin
      if (car_cnt_q == CarHalf - CW'(1)) begin
        phase_d   = ~phase_q;
        car_cnt_d = '0;
      end else begin
        car_cnt_d = car_cnt_q + CW'(1);
      end
    end
    out_d = (CarrierOn ? (env_d & phase_d) : env_d) ^ InvBit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      t_q       <= '0;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      car_cnt_q <= '0;
      phase_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      env_q     <= 1'b0;
      out_q     <= InvBit;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      car_cnt_q <= car_cnt_d;
      phase_q   <= phase_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      env_q     <= env_d;
      out_q     <= out_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.ir_env = env_q;
  assign bus.ir_out = out_q;

endmodule
